board_shift_tx: RTL and testbench

Serial transmitter that streams the 4x4 game board state to an external 74HC595-style shift-register chain driving the bicolor board LEDs. It sits beside `DetectWinner` and `DisplayGameStatus` under `connect4_top`, consuming the same `gameboard_out` and `player_cells` buses that `ColumnSelector` produces. It is the output end of the board interface; the switch and button column entry is the input end. The block snapshots the board, encodes each cell as two color bits, shifts the 32-bit frame out MSB-first, pulses a latch, then waits a refresh gap before the next frame.

---
 rtl/board_shift_tx_if.sv | 9 +
 rtl/board_shift_tx.sv | 125 ++++++++++++
 tb/tb_board_shift_tx.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/board_shift_tx_if.sv
// rtl/board_shift_tx_if.sv - serial bus to a 74HC595-style LED shift-register chain
interface board_shift_tx_if;
    logic sr_data;
    logic sr_clk;
    logic sr_latch;

    modport master (output sr_data, output sr_clk, output sr_latch);
    modport slave  (input  sr_data, input  sr_clk, input  sr_latch);
endinterface

// File: rtl/board_shift_tx.sv
// rtl/board_shift_tx.sv - streams the encoded 4x4 board as a 32-bit frame to the LED chain
module board_shift_tx #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [15:0]             game_board,
    input  logic [15:0]             player_cells,
    board_shift_tx_if.master        sr,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int MAX_DIV = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int DW      = $clog2(MAX_DIV) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] GAP_LAST = DW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, GAP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   word;
    logic [4:0]    bit_cnt;
    logic [DW-1:0] div;
    logic          div_last;
    logic          gap_last;

    // Red bit marks player 1, green bit marks player 2; empty cells stay dark.
    function automatic logic [31:0] encode(input logic [15:0] occ, input logic [15:0] owner);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 16; i++) begin
            w[2*i+1] = occ[i] & ~owner[i];
            w[2*i]   = occ[i] &  owner[i];
        end
        return w;
    endfunction

    assign div_last = (div == DIV_LAST);
    assign gap_last = (div == GAP_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word    <= '0;
            bit_cnt <= '0;
            div     <= '0;
        end else begin
            case (state)
                LOAD: begin
                    word    <= encode(game_board, player_cells);
                    bit_cnt <= 5'd31;
                    div     <= '0;
                end
                SHIFT_LO, LATCH: div <= div_last ? '0 : div + 1'b1;
                SHIFT_HI: begin
                    if (div_last) begin
                        div <= '0;
                        if (bit_cnt != 5'd0) begin
                            bit_cnt <= bit_cnt - 5'd1;
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                GAP:     div <= gap_last ? '0 : div + 1'b1;
                default: div <= '0;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (enable) state_nxt = LOAD;
            LOAD:     state_nxt = SHIFT_LO;
            SHIFT_LO: if (div_last) state_nxt = SHIFT_HI;
            SHIFT_HI: if (div_last) state_nxt = (bit_cnt == 5'd0) ? LATCH : SHIFT_LO;
            LATCH:    if (div_last) state_nxt = GAP;
            GAP:      if (gap_last) state_nxt = enable ? LOAD : IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Data tracks word[bit_cnt] outside IDLE so it only moves when the counter or word does.
    always_comb begin
        sr.sr_data  = 1'b0;
        sr.sr_clk   = 1'b0;
        sr.sr_latch = 1'b0;
        busy        = 1'b0;
        frame_done  = 1'b0;
        case (state)
            LOAD, SHIFT_LO: begin
                busy       = 1'b1;
                sr.sr_data = word[bit_cnt];
            end
            SHIFT_HI: begin
                busy       = 1'b1;
                sr.sr_clk  = 1'b1;
                sr.sr_data = word[bit_cnt];
            end
            LATCH: begin
                busy        = 1'b1;
                sr.sr_latch = 1'b1;
                sr.sr_data  = word[bit_cnt];
            end
            GAP: begin
                frame_done = (div == '0);
                sr.sr_data = word[bit_cnt];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_board_shift_tx.sv
// tb/tb_board_shift_tx.sv - directed bench for board_shift_tx at default and minimum parameters
module tb_board_shift_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_d;
    logic        en_m;
    logic [15:0] gb;
    logic [15:0] pc;
    logic        busy_d, done_d, busy_m, done_m;
    logic        sel;
    logic        o_data, o_clk, o_latch, o_busy, o_done;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    board_shift_tx_if b_d();
    board_shift_tx_if b_m();

    board_shift_tx dut (
        .clk(clk), .reset(reset), .enable(en_d), .game_board(gb), .player_cells(pc),
        .sr(b_d.master), .busy(busy_d), .frame_done(done_d)
    );

    board_shift_tx #(.CLK_DIV(1), .GAP_CYCLES(1)) dut_min (
        .clk(clk), .reset(reset), .enable(en_m), .game_board(gb), .player_cells(pc),
        .sr(b_m.master), .busy(busy_m), .frame_done(done_m)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        if (sel) {o_data, o_clk, o_latch, o_busy, o_done} = {b_m.sr_data, b_m.sr_clk, b_m.sr_latch, busy_m, done_m};
        else     {o_data, o_clk, o_latch, o_busy, o_done} = {b_d.sr_data, b_d.sr_clk, b_d.sr_latch, busy_d, done_d};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // act_kind: 0 none, 1 clear game_board, 2 drop enable, 3 return early (at rise act_at)
    task automatic run_frame(input int act_at, input int act_kind,
                             output logic [31:0] bits, output int rises, output int latch_w,
                             output int load_c, output int first_off, output int span,
                             output int latch_gap, output int done_off, output int stab_err,
                             output bit ok);
        int   n;
        int   first_c, last_c, latch_c;
        logic prev_clk, prev_data;
        bits = '0; rises = 0; latch_w = 0; load_c = 0; first_off = 0; span = 0;
        latch_gap = 0; done_off = 0; stab_err = 0; ok = 0;
        first_c = 0; last_c = 0; latch_c = 0;
        n = 0;
        while (o_busy !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        if (o_busy !== 1'b1) return;
        load_c    = cyc;
        prev_clk  = o_clk;
        prev_data = o_data;
        n = 0;
        while (n < 1200) begin
            tick();
            n++;
            if (o_clk === 1'b1 && prev_clk === 1'b0) begin
                if (o_data !== prev_data) stab_err++;
                bits = {bits[30:0], o_data};
                rises++;
                if (rises == 1) first_c = cyc;
                last_c = cyc;
                if (rises == act_at) begin
                    if (act_kind == 1) gb = 16'h0000;
                    else if (act_kind == 2) begin en_d = 1'b0; en_m = 1'b0; end
                    else if (act_kind == 3) begin ok = 1; return; end
                end
            end else if (o_clk === 1'b1 && o_data !== prev_data) begin
                stab_err++;
            end
            if (o_latch === 1'b1) begin
                if (latch_w == 0) latch_c = cyc;
                latch_w++;
            end
            if (o_done === 1'b1) begin
                ok = 1;
                break;
            end
            prev_clk  = o_clk;
            prev_data = o_data;
        end
        first_off = first_c - load_c;
        span      = last_c - first_c;
        latch_gap = latch_c - last_c;
        done_off  = cyc - load_c;
    endtask

    logic [31:0] bits;
    int rises, latch_w, load_c, first_off, span, latch_gap, done_off, stab_err;
    int prev_load, cnt;
    bit ok;

    initial begin
        reset = 1'b1; en_d = 1'b1; en_m = 1'b0; sel = 1'b0;
        gb = 16'h8001; pc = 16'h8000;

        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_outputs", {o_data, o_clk, o_latch, o_busy, o_done}, 5'b0);
        end
        reset = 1'b0;
        tick();
        check("first_load_busy", o_busy, 1'b1);

        run_frame(0, 0, bits, rises, latch_w, load_c, first_off, span, latch_gap, done_off, stab_err, ok);
        check("f1_done", ok, 1'b1);
        check("f1_bits", bits, 32'h4000_0002);
        check("f1_rises", rises, 32);
        check("f1_latch_width", latch_w, 4);
        check("f1_first_rise", first_off, 5);
        check("f1_rise_span", span, 248);
        check("f1_latch_after_hi", latch_gap, 4);
        check("f1_done_offset", done_off, 261);
        check("f1_stability", stab_err, 0);
        check("f1_busy_at_done", o_busy, 1'b0);
        prev_load = load_c;
        tick();
        check("f1_done_one_cycle", o_done, 1'b0);

        gb = 16'h0000; pc = 16'hFFFF;
        run_frame(0, 0, bits, rises, latch_w, load_c, first_off, span, latch_gap, done_off, stab_err, ok);
        check("period_default", load_c - prev_load, 277);
        check("invalid_owner_bits", bits, 32'h0);
        check("f2_done", ok, 1'b1);
        prev_load = load_c;

        gb = 16'hFFFF; pc = 16'h0000;
        run_frame(10, 1, bits, rises, latch_w, load_c, first_off, span, latch_gap, done_off, stab_err, ok);
        check("midframe_bits", bits, 32'hAAAA_AAAA);
        check("midframe_rises", rises, 32);
        prev_load = load_c;
        run_frame(0, 0, bits, rises, latch_w, load_c, first_off, span, latch_gap, done_off, stab_err, ok);
        check("next_frame_bits", bits, 32'h0);
        check("next_frame_period", load_c - prev_load, 277);

        gb = 16'h0F0F; pc = 16'h00FF;
        run_frame(5, 2, bits, rises, latch_w, load_c, first_off, span, latch_gap, done_off, stab_err, ok);
        check("en_drop_done", ok, 1'b1);
        check("en_drop_bits", bits, 32'h00AA_0055);
        check("en_drop_latch", latch_w, 4);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (o_busy === 1'b1) cnt++;
        end
        check("en_drop_no_reload", cnt, 0);

        gb = 16'hFFFF; pc = 16'h5555; en_d = 1'b1;
        run_frame(20, 3, bits, rises, latch_w, load_c, first_off, span, latch_gap, done_off, stab_err, ok);
        check("reset_mid_reached", ok, 1'b1);
        check("reset_mid_rises", rises, 20);
        reset = 1'b1; en_d = 1'b0;
        tick();
        check("reset_mid_outputs", {o_data, o_clk, o_latch, o_busy, o_done}, 5'b0);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (o_latch === 1'b1 || o_busy === 1'b1) cnt++;
        end
        check("reset_mid_no_latch", cnt, 0);

        sel = 1'b1;
        gb = 16'h3C5A; pc = 16'h0F0F; en_m = 1'b1;
        run_frame(0, 0, bits, rises, latch_w, load_c, first_off, span, latch_gap, done_off, stab_err, ok);
        check("min_done", ok, 1'b1);
        check("min_bits", bits, 32'h0A50_2244);
        check("min_rises", rises, 32);
        check("min_latch_width", latch_w, 1);
        check("min_first_rise", first_off, 2);
        check("min_rise_span", span, 62);
        check("min_latch_after_hi", latch_gap, 1);
        check("min_done_offset", done_off, 66);
        check("min_stability", stab_err, 0);
        prev_load = load_c;
        run_frame(0, 0, bits, rises, latch_w, load_c, first_off, span, latch_gap, done_off, stab_err, ok);
        en_m = 1'b0;
        check("min_period", load_c - prev_load, 67);
        check("min_bits_repeat", bits, 32'h0A50_2244);
        tick();
        tick();
        check("min_idle_after", o_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
